// File: rtl/tff_updown_counter.sv
// Parametrised up/down modulo counter stored in per-bit T flip-flops with async clear.
// Define COUNTER_SATURATE_EN to make the counter stop at its limits instead of wrapping.
module tff_updown_counter #(
  parameter int WIDTH     = 8,
  parameter int MAX_COUNT = (1 << WIDTH) - 1
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MAX_COUNT);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_nq;
  logic [WIDTH-1:0] w_t;
  logic [WIDTH-1:0] w_up_lim;
  logic [WIDTH-1:0] w_dn_lim;
  logic             w_at_max;
  logic             w_at_zero;

  assign w_at_max  = (r_q == MAX_VAL);
  assign w_at_zero = (r_q == '0);

  // Value taken when stepping past either end: wrap-around or stick at the limit.
`ifdef COUNTER_SATURATE_EN
  assign w_up_lim = MAX_VAL;
  assign w_dn_lim = '0;
  assign wrap     = 1'b0;
`else
  logic r_wrap;

  assign w_up_lim = '0;
  assign w_dn_lim = MAX_VAL;
  assign wrap     = r_wrap;

  always_ff @(posedge clk or posedge clear) begin
    if (clear) r_wrap <= 1'b0;
    else       r_wrap <= tc;
  end
`endif

  always_comb begin
    w_nq = r_q;
    if (load) begin
      w_nq = (load_val > MAX_VAL) ? MAX_VAL : load_val;
    end else if (en) begin
      if (up_dn) w_nq = w_at_max  ? w_up_lim : r_q + 1'b1;
      else       w_nq = w_at_zero ? w_dn_lim : r_q - 1'b1;
    end
  end

  assign tc  = en & ~load & (up_dn ? w_at_max : w_at_zero);
  assign w_t = r_q ^ w_nq;

  // Bank of T flip-flops: each bit flips only when its toggle input is set.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      r_q <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (w_t[i]) r_q[i] <= ~r_q[i];
      end
    end
  end

  assign q = r_q;

endmodule
